// File: rtl/switch_debounce_counter_pkg.sv
// Shared board constants for the switch/counter path.
// Contents: default debounce length at 25 MHz, switch count and switch index assignments.
package switch_debounce_counter_pkg;

    // 10 ms at 25 MHz
    localparam int unsigned DEBOUNCE_CYCLES_25MHZ = 250000;

    localparam int unsigned NUM_SW = 4;

    // Bit positions of each switch function within the press/stable vectors
    localparam int unsigned SW_INC   = 0;
    localparam int unsigned SW_DEC   = 1;
    localparam int unsigned SW_ADD16 = 2;
    localparam int unsigned SW_CLR   = 3;

    typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/switch_debounce_counter_debounce.sv
// Single-switch conditioner: 2-flop synchronizer followed by a stability counter.
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     synchronous active-high reset
//   i_raw     raw asynchronous switch level
//   o_stable  debounced level
//   o_rise    one-cycle pulse when o_stable goes 0->1
module switch_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int unsigned CNT_BITS = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic                s1;
    logic                s2;
    logic [CNT_BITS-1:0] cnt;

    // Synchronize, then accept s2 only after it differs from o_stable for DEBOUNCE_CYCLES edges
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            o_stable <= 1'b0;
            o_rise   <= 1'b0;
        end else begin
            s1     <= i_raw;
            s2     <= s1;
            o_rise <= 1'b0;
            if (s2 == o_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                o_stable <= s2;
                cnt      <= '0;
                // Only a settled 0->1 level change counts as a press
                o_rise   <= s2;
            end else begin
                cnt <= cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/switch_debounce_counter.sv
// Debounces the four board switches and turns presses into a byte for bin_to_7seg.
// Switch 1 = +1, switch 2 = -1, switch 3 = +0x10, switch 4 = clear (wins over the others).
// Ports:
//   i_clk               system clock, rising edge
//   i_rst               synchronous active-high reset
//   i_switch_1..4       raw asynchronous switch inputs
//   o_byte   [CNT_W]    counter value, wraps modulo 2^CNT_W
//   o_stable [4]        debounced switch levels, bit0 = switch_1
//   o_press  [4]        one-cycle pulse per debounced press
module switch_debounce_counter
    import switch_debounce_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25MHZ,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_switch_1,
    input  logic             i_switch_2,
    input  logic             i_switch_3,
    input  logic             i_switch_4,
    output logic [CNT_W-1:0] o_byte,
    output logic [3:0]       o_stable,
    output logic [3:0]       o_press
);

    sw_vec_t          raw;
    logic [CNT_W-1:0] delta_c;

    assign raw = {i_switch_4, i_switch_3, i_switch_2, i_switch_1};

    // One conditioner per switch
    for (genvar g = 0; g < int'(NUM_SW); g++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (raw[g]),
            .o_stable(o_stable[g]),
            .o_rise  (o_press[g])
        );
    end

    // Net change from the arithmetic presses; inc and dec together cancel
    always_comb begin
        delta_c = '0;
        if (o_press[SW_INC])   delta_c = delta_c + CNT_W'(1);
        if (o_press[SW_DEC])   delta_c = delta_c - CNT_W'(1);
        if (o_press[SW_ADD16]) delta_c = delta_c + CNT_W'(16);
    end

    // Counter register; clear overrides any simultaneous press
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_byte <= '0;
        end else if (o_press[SW_CLR]) begin
            o_byte <= '0;
        end else begin
            o_byte <= o_byte + delta_c;
        end
    end

endmodule

// File: tb/tb_switch_debounce_counter.sv
module tb_switch_debounce_counter;

    localparam int unsigned DEB = 4;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [7:0] o_byte;
    logic [3:0] o_stable;
    logic [3:0] o_press;

    int n_checks;
    int n_fail;
    int unsigned press_cnt[4];
    int unsigned snap[4];

    typedef struct {
        logic [3:0] mask;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[12];

    switch_debounce_counter #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_switch_1(sw[0]),
        .i_switch_2(sw[1]),
        .i_switch_3(sw[2]),
        .i_switch_4(sw[3]),
        .o_byte    (o_byte),
        .o_stable  (o_stable),
        .o_press   (o_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count press pulses per switch, sampled mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (o_press[i]) press_cnt[i] = press_cnt[i] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic take_snap();
        for (int i = 0; i < 4; i++) snap[i] = press_cnt[i];
    endtask

    // Press counts since the last snapshot, one byte per switch
    function automatic logic [31:0] press_diff();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(press_cnt[i] - snap[i]);
        return r;
    endfunction

    function automatic logic [31:0] mask_to_diff(input logic [3:0] m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = {7'd0, m[i]};
        return r;
    endfunction

    task automatic do_press(input logic [3:0] m);
        sw = m;
        repeat (8) tick();
        sw = 4'h0;
        repeat (8) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0;
            snap[i]      = 0;
        end

        vecs[0]  = '{4'b1000, 8'h00};
        vecs[1]  = '{4'b0001, 8'h01};
        vecs[2]  = '{4'b0010, 8'h00};
        vecs[3]  = '{4'b0010, 8'hFF};
        vecs[4]  = '{4'b0001, 8'h00};
        vecs[5]  = '{4'b0100, 8'h10};
        vecs[6]  = '{4'b0011, 8'h10};
        vecs[7]  = '{4'b1001, 8'h00};
        vecs[8]  = '{4'b0101, 8'h11};
        vecs[9]  = '{4'b0110, 8'h20};
        vecs[10] = '{4'b1111, 8'h00};
        vecs[11] = '{4'b0111, 8'h10};

        // 1. Reset with all switches high
        rst = 1'b1;
        sw  = 4'hF;
        tick();
        tick();
        chk("rst_byte",   32'(o_byte),   32'h00);
        chk("rst_stable", 32'(o_stable), 32'h0);
        chk("rst_press",  32'(o_press),  32'h0);
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_e5_stable", 32'(o_stable), 32'h0);
        tick();
        chk("post_rst_e6_stable", 32'(o_stable), 32'hF);
        chk("post_rst_e6_press",  32'(o_press),  32'hF);
        tick();
        chk("post_rst_e7_press", 32'(o_press), 32'h0);
        chk("post_rst_e7_byte",  32'(o_byte),  32'h00);
        take_snap();
        sw = 4'h0;
        repeat (10) tick();
        chk("release_stable",   32'(o_stable),  32'h0);
        chk("release_no_press", press_diff(),   32'h0);

        // 2. Single press latency and no auto-repeat
        take_snap();
        sw = 4'b0001;
        repeat (5) tick();
        chk("inc_e5_stable", 32'(o_stable), 32'h0);
        tick();
        chk("inc_e6_stable", 32'(o_stable), 32'h1);
        chk("inc_e6_press",  32'(o_press),  32'h1);
        chk("inc_e6_byte",   32'(o_byte),   32'h00);
        tick();
        chk("inc_e7_press", 32'(o_press), 32'h0);
        chk("inc_e7_byte",  32'(o_byte),  32'h01);
        repeat (100) tick();
        chk("hold_byte",  32'(o_byte),  32'h01);
        chk("hold_count", press_diff(), mask_to_diff(4'b0001));
        sw = 4'h0;
        repeat (10) tick();

        // 3. Bounce then hold gives exactly one press
        take_snap();
        sw = 4'b0001; tick(); tick();
        sw = 4'b0000; tick(); tick();
        sw = 4'b0001; tick(); tick();
        sw = 4'b0000; tick(); tick();
        sw = 4'b0001;
        repeat (20) tick();
        chk("bounce_count", press_diff(), mask_to_diff(4'b0001));
        chk("bounce_byte",  32'(o_byte),  32'h02);
        sw = 4'h0;
        repeat (10) tick();
        // Glitch one cycle shorter than the debounce window
        take_snap();
        sw = 4'b0001;
        repeat (3) tick();
        sw = 4'b0000;
        repeat (12) tick();
        chk("glitch_count",  press_diff(),   32'h0);
        chk("glitch_stable", 32'(o_stable),  32'h0);
        chk("glitch_byte",   32'(o_byte),    32'h02);

        // Table: arithmetic, wrap and simultaneous presses
        for (int v = 0; v < 12; v++) begin
            take_snap();
            do_press(vecs[v].mask);
            chk($sformatf("vec%0d_byte", v),  32'(o_byte), 32'(vecs[v].exp_byte));
            chk($sformatf("vec%0d_press", v), press_diff(), mask_to_diff(vecs[v].mask));
        end

        // 4. Add16 wrap from 0xF5
        do_press(4'b1000);
        for (int k = 0; k < 11; k++) do_press(4'b0010);
        chk("preload_f5", 32'(o_byte), 32'hF5);
        do_press(4'b0100);
        chk("add16_wrap", 32'(o_byte), 32'h05);

        // 6a. Reset mid-debounce with switch released right after
        take_snap();
        sw = 4'b0010;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_byte",   32'(o_byte),   32'h00);
        chk("midrst_stable", 32'(o_stable), 32'h0);
        sw = 4'b0000;
        repeat (15) tick();
        chk("midrst_no_press", press_diff(),  32'h0);
        chk("midrst_byte2",    32'(o_byte),   32'h00);

        // 6b. Reset mid-debounce with switch still held: press arrives 6 edges later
        take_snap();
        sw = 4'b0010;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("held_e5_stable", 32'(o_stable), 32'h0);
        tick();
        chk("held_e6_stable", 32'(o_stable), 32'h2);
        chk("held_e6_press",  32'(o_press),  32'h2);
        tick();
        chk("held_e7_byte", 32'(o_byte), 32'hFF);
        sw = 4'h0;
        repeat (10) tick();
        chk("held_count", press_diff(), mask_to_diff(4'b0010));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
